// File: rtl/age_rs_pkg.sv
// Shared types and age arithmetic for the out-of-order back end (RS, ROB, LSQ).
// Age is measured from the ROB head so that tag wrap-around orders correctly.
package age_rs_pkg;

    // Per-entry status bits; wide fields live in parallel arrays sized by the owner.
    typedef struct packed {
        logic valid;
        logic rs1_ready;
        logic rs2_ready;
    } rs_entry_t;

    function automatic logic [31:0] age_of(input logic [31:0] tag, input logic [31:0] head,
                                           input int unsigned width);
        logic [31:0] mask;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (tag - head) & mask;
    endfunction

endpackage

// File: rtl/age_select.sv
// Picks the requesting entry with the smallest age relative to head.
// Ties resolve to the lowest index because only a strictly smaller age replaces the pick.
module age_select
    import age_rs_pkg::*;
#(
    parameter int unsigned RS_SIZE   = 8,
    parameter int unsigned ROB_WIDTH = 4,
    localparam int unsigned IW       = $clog2(RS_SIZE)
) (
    input  logic [RS_SIZE-1:0]                req,
    input  logic [RS_SIZE-1:0][ROB_WIDTH-1:0] tags,
    input  logic [ROB_WIDTH-1:0]              head,
    output logic                              found,
    output logic [IW-1:0]                     idx
);

    logic [31:0] cur_age;
    logic [31:0] best_age;

    always_comb begin
        found    = 1'b0;
        idx      = '0;
        cur_age  = '0;
        best_age = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            cur_age = age_of(32'(tags[i]), 32'(head), ROB_WIDTH);
            if (req[i] && (!found || cur_age < best_age)) begin
                found    = 1'b1;
                idx      = IW'(i);
                best_age = cur_age;
            end
        end
    end

endmodule

// File: rtl/age_rs.sv
// Age-ordered reservation station: allocates into the lowest free slot, wakes sources
// from the CDB, issues the oldest ready entry and flushes younger entries on mispredict.
module age_rs
    import age_rs_pkg::*;
#(
    parameter int unsigned PREG_WIDTH = 7,
    parameter int unsigned ROB_WIDTH  = 4,
    parameter int unsigned RS_SIZE    = 8,
    parameter int unsigned CDB_PORTS  = 2,
    parameter int unsigned PAYLOAD_W  = 70,
    localparam int unsigned CW        = $clog2(RS_SIZE + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_valid,
    input  logic [PREG_WIDTH-1:0]           i_prs1,
    input  logic [PREG_WIDTH-1:0]           i_prs2,
    input  logic [PREG_WIDTH-1:0]           i_prd,
    input  logic [ROB_WIDTH-1:0]            i_rob_tag,
    input  logic [PAYLOAD_W-1:0]            i_payload,
    input  logic                            i_rs1_ready,
    input  logic                            i_rs2_ready,
    output logic                            o_full,
    output logic [CW-1:0]                   o_count,
    input  logic [CDB_PORTS-1:0]            i_cdb_valid,
    input  logic [CDB_PORTS*PREG_WIDTH-1:0] i_cdb_prd,
    input  logic [ROB_WIDTH-1:0]            i_rob_head,
    input  logic                            i_eu_ready,
    output logic                            o_issue_valid,
    output logic [PREG_WIDTH-1:0]           o_issue_prs1,
    output logic [PREG_WIDTH-1:0]           o_issue_prs2,
    output logic [PREG_WIDTH-1:0]           o_issue_prd,
    output logic [ROB_WIDTH-1:0]            o_issue_rob_tag,
    output logic [PAYLOAD_W-1:0]            o_issue_payload,
    input  logic                            branch_mispredict,
    input  logic [ROB_WIDTH-1:0]            mispredict_rob_tag
);

    localparam int unsigned IW = $clog2(RS_SIZE);

    rs_entry_t             ent_q   [RS_SIZE];
    rs_entry_t             ent_d   [RS_SIZE];
    logic [PREG_WIDTH-1:0] prs1_q  [RS_SIZE];
    logic [PREG_WIDTH-1:0] prs2_q  [RS_SIZE];
    logic [PREG_WIDTH-1:0] prd_q   [RS_SIZE];
    logic [ROB_WIDTH-1:0]  tag_q   [RS_SIZE];
    logic [PAYLOAD_W-1:0]  pay_q   [RS_SIZE];

    logic                              free_found;
    logic [IW-1:0]                     free_idx;
    logic                              alloc_fire;
    logic [RS_SIZE-1:0]                ready_vec;
    logic [RS_SIZE-1:0][ROB_WIDTH-1:0] tag_vec;
    logic                              sel_found;
    logic [IW-1:0]                     sel_idx;
    logic                              issue_fire;
    logic [31:0]                       mp_age;
    logic [CW-1:0]                     count;

    // Preg 0 is the hardwired zero register and never appears as a wakeup.
    function automatic logic cdb_hit(input logic [PREG_WIDTH-1:0]           prs,
                                     input logic [CDB_PORTS-1:0]            v,
                                     input logic [CDB_PORTS*PREG_WIDTH-1:0] prd);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < int'(CDB_PORTS); p++) begin
            if (v[p] && prd[p*PREG_WIDTH +: PREG_WIDTH] == prs && prs != '0) hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        count      = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            if (!ent_q[i].valid && !free_found) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
            count        = count + CW'(ent_q[i].valid);
            ready_vec[i] = ent_q[i].valid && ent_q[i].rs1_ready && ent_q[i].rs2_ready;
            tag_vec[i]   = tag_q[i];
        end
    end

    assign o_count    = count;
    assign o_full     = (count == CW'(RS_SIZE));
    assign alloc_fire = i_valid && !o_full && free_found && !branch_mispredict;
    assign mp_age     = age_of(32'(mispredict_rob_tag), 32'(i_rob_head), ROB_WIDTH);

    age_select #(
        .RS_SIZE   (RS_SIZE),
        .ROB_WIDTH (ROB_WIDTH)
    ) u_age_select (
        .req   (ready_vec),
        .tags  (tag_vec),
        .head  (i_rob_head),
        .found (sel_found),
        .idx   (sel_idx)
    );

    assign issue_fire = sel_found && i_eu_ready;

    always_comb begin
        o_issue_valid   = sel_found;
        o_issue_prs1    = '0;
        o_issue_prs2    = '0;
        o_issue_prd     = '0;
        o_issue_rob_tag = '0;
        o_issue_payload = '0;
        if (sel_found) begin
            o_issue_prs1    = prs1_q[sel_idx];
            o_issue_prs2    = prs2_q[sel_idx];
            o_issue_prd     = prd_q[sel_idx];
            o_issue_rob_tag = tag_q[sel_idx];
            o_issue_payload = pay_q[sel_idx];
        end
    end

    always_comb begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].valid) begin
                ent_d[i].rs1_ready = ent_q[i].rs1_ready | cdb_hit(prs1_q[i], i_cdb_valid, i_cdb_prd);
                ent_d[i].rs2_ready = ent_q[i].rs2_ready | cdb_hit(prs2_q[i], i_cdb_valid, i_cdb_prd);
            end
            if (issue_fire && sel_idx == IW'(i)) ent_d[i] = '0;
            if (branch_mispredict &&
                age_of(32'(tag_q[i]), 32'(i_rob_head), ROB_WIDTH) > mp_age) begin
                ent_d[i] = '0;
            end
            // Allocation only targets a free slot, so it never collides with issue or flush.
            if (alloc_fire && free_idx == IW'(i)) begin
                ent_d[i].valid     = 1'b1;
                ent_d[i].rs1_ready = i_rs1_ready | cdb_hit(i_prs1, i_cdb_valid, i_cdb_prd);
                ent_d[i].rs2_ready = i_rs2_ready | cdb_hit(i_prs2, i_cdb_valid, i_cdb_prd);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            if (reset) ent_q[i] <= '0;
            else       ent_q[i] <= ent_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire && !reset) begin
            prs1_q[free_idx] <= i_prs1;
            prs2_q[free_idx] <= i_prs2;
            prd_q[free_idx]  <= i_prd;
            tag_q[free_idx]  <= i_rob_tag;
            pay_q[free_idx]  <= i_payload;
        end
    end

endmodule
